ibex_icache_scr_key_ctrl: RTL and testbench
===========================================

// Module: ibex_icache_scr_key_ctrl
// PURPOSE
//  Scramble-key controller feeding the icache tag/data RAM instantiation stage.
//  - Fetches a key/nonce from the key manager after reset and on every fence.i.
//  - Registers key/nonce and drives key-valid to the scrambled RAM banks.
//  - Sequences the icache invalidation that must follow each key change, since old lines are unreadable under the new key.
// PARAMETERS
//  ICacheScramble    1'b1  1: key fetch enabled; 0: fence.i only invalidates, key fixed at 0
//  KeyTimeoutCycles  256   cycles in S_REQ without a key before a timeout retry (>=2)
//  TimeoutCntW       $clog2(KeyTimeoutCycles)  derived; do not override
// PORTS
//  clk_i                 in   1                 clock
//  rst_i                 in   1                 synchronous reset, active-high
//  fence_req_i           in   1                 1-cycle pulse: fence.i, request rekey+invalidate
//  scramble_req_o        out  1                 key request to key manager, level
//  scramble_key_valid_i  in   1                 key manager response strobe
//  scramble_key_i        in   SCRAMBLE_KEY_W    key, valid with strobe
//  scramble_nonce_i      in   SCRAMBLE_NONCE_W  nonce, valid with strobe
//  scramble_key_valid_d  out  1                 next-state value of scramble_key_valid_q
//  scramble_key_valid_q  out  1                 registered key valid to RAM banks
//  scramble_key_q        out  SCRAMBLE_KEY_W    registered key to RAM banks
//  scramble_nonce_q      out  SCRAMBLE_NONCE_W  registered nonce to RAM banks
//  ic_inval_o            out  1                 invalidate request to icache, level
//  ic_inval_done_i       in   1                 icache invalidation complete, 1-cycle pulse
//  busy_o                out  1                 state != S_IDLE; core stalls fetch while high
//  key_timeout_o         out  1                 1-cycle pulse on key-request timeout
// BEHAVIOUR
//  Reset: all outputs 0; key_q/nonce_q=0; pending=0; state<=S_REQ (ICacheScramble=0: S_INVAL).
//  S_REQ
//   - scramble_req_o=1; key_valid_q=0.
//   - On scramble_key_valid_i: capture key/nonce; key_valid_q=1 next cycle; ->S_INVAL.
//  S_INVAL
//   - ic_inval_o=1 until ic_inval_done_i is sampled high.
//   - On done: ->S_REQ if pending (pending cleared), else ->S_IDLE.
//  S_IDLE
//   - fence_req_i: ICacheScramble=1 ->S_REQ, key_valid_q cleared next cycle; ICacheScramble=0 ->S_INVAL.
//  ICacheScramble=0: scramble_req_o=0; key_valid_q=1 from 1st post-reset cycle; key/nonce stay 0.
//  scramble_key_valid_d: combinational; equals key_valid_q's value in the next cycle.
//  fence_req_i in S_REQ/S_INVAL: sets pending (single bit; multiple fences collapse to one).
//  fence_req_i with key strobe in same S_REQ cycle: key captured AND pending set.
//  scramble_key_valid_i outside S_REQ: ignored; no capture; key_q unchanged.
//  ic_inval_done_i outside S_INVAL: ignored.
//  Reset mid-sequence: abandons request/invalidation, state returns to reset values, sequence restarts.
//  Latency: key strobe -> key_valid_q=1 at +1 cycle; ic_inval_o=1 at +1 cycle.
//  busy_o: registered-state decode; 0 only in S_IDLE.
// CONFIGURATION
//  IBEX_SCR_KEY_TIMEOUT_EN defined
//   - TimeoutCntW-bit counter runs in S_REQ; cleared on entry/capture.
//   - At count==KeyTimeoutCycles-1 with no strobe: key_timeout_o=1 for 1 cycle; counter wraps to 0.
//   - scramble_req_o=0 for that cycle, then re-asserted (retry); state stays S_REQ.
//  Not defined: no counter; key_timeout_o tied 0; S_REQ waits indefinitely.
// STRUCTURE
//  ibex_pkg
//   - Uses existing SCRAMBLE_KEY_W/SCRAMBLE_NONCE_W.
//   - Adds typedef enum logic [1:0] {S_IDLE,S_REQ,S_INVAL} scr_key_state_e.
//  Sub-module ibex_scr_key_timer, instantiated only under IBEX_SCR_KEY_TIMEOUT_EN:
//   - inputs clk_i, rst_i, en_i, clr_i; output expire_o.
//  All other logic (FSM, pending bit, key/nonce registers) is flat in this module.
// TESTING
//  1 Reset release, key strobe at cycle 5 (key=0xA5..A5)
//    -> req high cycles 1-5; key_valid_q=1 and key_q=0xA5..A5 at cycle 6; ic_inval_o=1 from cycle 6.
//  2 In S_IDLE, fence_req_i pulse
//    -> key_valid_q=0 next cycle; scramble_req_o=1; new key captured; ic_inval_o until done; busy_o=0 after.
//  3 Two fence_req_i pulses during S_INVAL
//    -> exactly one further S_REQ/S_INVAL round after done; then S_IDLE.
//  4 Key strobe while S_IDLE (key=0x1234)
//    -> key_q unchanged; key_valid_q stays 1; no state change.
//  5 IBEX_SCR_KEY_TIMEOUT_EN, KeyTimeoutCycles=8, no strobe
//    -> key_timeout_o pulses at cycles 8,16; req low on those cycles; late strobe still captured.
//  6 rst_i asserted 1 cycle mid-S_INVAL; ICacheScramble=0 variant
//    -> outputs 0, restart at S_REQ; variant: fence -> ic_inval_o only, req stays 0.

Source files
------------

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared scramble widths and key-controller state encoding
package ibex_pkg;
  localparam int unsigned SCRAMBLE_KEY_W   = 128;
  localparam int unsigned SCRAMBLE_NONCE_W = 64;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_INVAL} scr_key_state_e;
endpackage

// File: rtl/ibex_scr_key_timer.sv
// ibex_scr_key_timer: key-request timeout counter, expires once every Cycles enabled cycles
module ibex_scr_key_timer #(
  parameter int unsigned Cycles = 256,
  parameter int unsigned CntW   = $clog2(Cycles)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);
  logic [CntW-1:0] cnt_q;
  assign expire_o = en_i & ~clr_i & (cnt_q == CntW'(Cycles - 1));
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || expire_o) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/ibex_icache_scr_key_ctrl.sv
// ibex_icache_scr_key_ctrl: fetches icache scramble key/nonce and sequences the following invalidation.
// Optional key-request timeout/retry enabled by defining IBEX_SCR_KEY_TIMEOUT_EN.
module ibex_icache_scr_key_ctrl
  import ibex_pkg::*;
#(
  parameter bit          ICacheScramble   = 1'b1,
  parameter int unsigned KeyTimeoutCycles = 256,
  parameter int unsigned TimeoutCntW      = $clog2(KeyTimeoutCycles)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        fence_req_i,
  output logic                        scramble_req_o,
  input  logic                        scramble_key_valid_i,
  input  logic [SCRAMBLE_KEY_W-1:0]   scramble_key_i,
  input  logic [SCRAMBLE_NONCE_W-1:0] scramble_nonce_i,
  output logic                        scramble_key_valid_d,
  output logic                        scramble_key_valid_q,
  output logic [SCRAMBLE_KEY_W-1:0]   scramble_key_q,
  output logic [SCRAMBLE_NONCE_W-1:0] scramble_nonce_q,
  output logic                        ic_inval_o,
  input  logic                        ic_inval_done_i,
  output logic                        busy_o,
  output logic                        key_timeout_o
);
  // Without scrambling there is no key to fetch, so a rekey is just an invalidation
  localparam scr_key_state_e Rekey = ICacheScramble ? S_REQ : S_INVAL;
  scr_key_state_e state_q, state_d;
  logic pending_q, pending_d;
  logic in_req, in_inval, in_idle, key_take, timeout;
  assign in_req   = state_q == S_REQ;
  assign in_inval = state_q == S_INVAL;
  assign in_idle  = state_q == S_IDLE;
  assign key_take = in_req & scramble_key_valid_i;
`ifdef IBEX_SCR_KEY_TIMEOUT_EN
  ibex_scr_key_timer #(
    .Cycles(KeyTimeoutCycles),
    .CntW  (TimeoutCntW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (in_req),
    .clr_i   (~in_req | scramble_key_valid_i),
    .expire_o(timeout)
  );
`else
  localparam int unsigned unused_timeout_cfg = KeyTimeoutCycles + TimeoutCntW;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = key_take ? S_INVAL :
              (in_inval & ic_inval_done_i) ? ((pending_q | fence_req_i) ? Rekey : S_IDLE) :
              (in_idle & fence_req_i) ? Rekey : state_q;
    pending_d = (in_inval & ic_inval_done_i) ? 1'b0 : pending_q | (fence_req_i & ~in_idle);
    scramble_key_valid_d = rst_i ? 1'b0 :
                           ~ICacheScramble | ((state_d != S_REQ) & (scramble_key_valid_q | in_req));
  end
  always_ff @(posedge clk_i) begin
    scramble_key_valid_q <= scramble_key_valid_d;
    if (rst_i) begin
      state_q          <= ICacheScramble ? S_REQ : S_INVAL;
      pending_q        <= 1'b0;
      scramble_key_q   <= '0;
      scramble_nonce_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (key_take) begin
        scramble_key_q   <= scramble_key_i;
        scramble_nonce_q <= scramble_nonce_i;
      end
    end
  end
  assign scramble_req_o = in_req & ~timeout;
  assign ic_inval_o     = in_inval;
  assign busy_o         = ~in_idle;
  assign key_timeout_o  = timeout;
endmodule

// File: tb/tb_ibex_icache_scr_key_ctrl.sv
// tb_ibex_icache_scr_key_ctrl: scoreboarded bench for the icache scramble-key controller
module tb_ibex_icache_scr_key_ctrl;
  import ibex_pkg::*;
  localparam int unsigned KTO = 8;
`ifdef IBEX_SCR_KEY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    logic [SCRAMBLE_KEY_W-1:0]   k;
    logic [SCRAMBLE_NONCE_W-1:0] n;
  } exp_t;
  logic clk = 0, rst = 1, fence = 0, kv = 0, done = 0, fence1 = 0, done1 = 0;
  logic [SCRAMBLE_KEY_W-1:0]   key = '0;
  logic [SCRAMBLE_NONCE_W-1:0] nonce = '0;
  logic req, kvd, kvq, inval, busy, tmo;
  logic req1, kvd1, kvq1, inval1, busy1, tmo1;
  logic [SCRAMBLE_KEY_W-1:0]   kq, kq1;
  logic [SCRAMBLE_NONCE_W-1:0] nq, nq1;
  int tests = 0, fails = 0;
  exp_t exp_q[$];
  exp_t e;
  logic kv_prev = 0;
  ibex_icache_scr_key_ctrl #(.KeyTimeoutCycles(KTO)) u0 (
    .clk_i(clk), .rst_i(rst), .fence_req_i(fence), .scramble_req_o(req),
    .scramble_key_valid_i(kv), .scramble_key_i(key), .scramble_nonce_i(nonce),
    .scramble_key_valid_d(kvd), .scramble_key_valid_q(kvq), .scramble_key_q(kq),
    .scramble_nonce_q(nq), .ic_inval_o(inval), .ic_inval_done_i(done),
    .busy_o(busy), .key_timeout_o(tmo)
  );
  ibex_icache_scr_key_ctrl #(.ICacheScramble(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .fence_req_i(fence1), .scramble_req_o(req1),
    .scramble_key_valid_i(kv), .scramble_key_i(key), .scramble_nonce_i(nonce),
    .scramble_key_valid_d(kvd1), .scramble_key_valid_q(kvq1), .scramble_key_q(kq1),
    .scramble_nonce_q(nq1), .ic_inval_o(inval1), .ic_inval_done_i(done1),
    .busy_o(busy1), .key_timeout_o(tmo1)
  );
  always #5 clk = ~clk;
  task automatic chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic chkw(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic give_key(logic [127:0] k, logic [63:0] n);
    kv = 1; key = k; nonce = n;
    exp_q.push_back('{k, n});
    step();
    kv = 0;
  endtask
  task automatic pulse_done();
    done = 1;
    step();
    done = 0;
  endtask
  // Monitor: every rising key_valid_q must present the next expected key, with invalidation already raised
  always @(negedge clk) begin
    if (kvq && !kv_prev) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL key_rise: got unexpected key_valid_q rise, key_q=%0h", kq);
      end else begin
        e = exp_q.pop_front();
        chkw("mon_key_q", kq, e.k);
        chkw("mon_nonce_q", 128'(nq), 128'(e.n));
        chk1("mon_inval_with_key", inval, 1'b1);
      end
    end
    kv_prev = kvq;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    rst = 0;
    smp();
    chk1("rst_kvq", kvq, 1'b0);
    chkw("rst_key", kq, '0);
    chk1("rst_inval", inval, 1'b0);
    chk1("rst_req", req, 1'b1);
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_tmo", tmo, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step(); smp();
      chk1("req_wait", req, 1'b1);
    end
    step();
    kv = 1; key = {16{8'hA5}}; nonce = 64'h0123_4567_89AB_CDEF;
    exp_q.push_back('{key, nonce});
    smp();
    chk1("kvd_on_strobe", kvd, 1'b1);
    step();
    kv = 0;
    smp();
    chk1("t1_kvq", kvq, 1'b1);
    chk1("t1_inval", inval, 1'b1);
    chk1("t1_req_low", req, 1'b0);
    step(); smp();
    chk1("t1_inval_hold", inval, 1'b1);
    pulse_done(); smp();
    chk1("t1_idle_busy", busy, 1'b0);
    chk1("t1_idle_inval", inval, 1'b0);
    // key strobe while idle must be ignored
    kv = 1; key = 128'h1234;
    step();
    kv = 0;
    smp();
    chkw("t4_key_kept", kq, {16{8'hA5}});
    chk1("t4_kvq", kvq, 1'b1);
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_req", req, 1'b0);
    fence = 1;
    smp();
    chk1("t2_kvd_fence", kvd, 1'b0);
    step();
    fence = 0;
    smp();
    chk1("t2_kvq_clr", kvq, 1'b0);
    chk1("t2_req", req, 1'b1);
    chk1("t2_busy", busy, 1'b1);
    give_key(128'hDEAD_BEEF_0000_0002, 64'h2222);
    smp();
    chk1("t2_inval", inval, 1'b1);
    fence = 1; step(); fence = 0; step();
    fence = 1; step(); fence = 0; step();
    smp();
    chk1("t3_still_inval", inval, 1'b1);
    pulse_done(); smp();
    chk1("t3_pend_req", req, 1'b1);
    chk1("t3_pend_kvq", kvq, 1'b0);
    chk1("t3_pend_inval", inval, 1'b0);
    give_key(128'hFACE_0000_0000_0003, 64'h3333);
    pulse_done();
    repeat (3) step();
    smp();
    chk1("t3_one_round_busy", busy, 1'b0);
    chk1("t3_one_round_req", req, 1'b0);
    fence = 1; step(); fence = 0;
    fence = 1;
    give_key(128'h4444_0000_0000_0004, 64'h4444);
    fence = 0;
    smp();
    chk1("t3b_inval", inval, 1'b1);
    pulse_done(); smp();
    chk1("t3b_fence_strobe_req", req, 1'b1);
    give_key(128'h5555_0000_0000_0005, 64'h5555);
    pulse_done(); smp();
    chk1("t3b_idle", busy, 1'b0);
    fence = 1; step(); fence = 0;
    for (int i = 0; i < 2 * KTO; i++) begin
      smp();
      chk1("t5_tmo", tmo, TO_EN && (i == KTO - 1 || i == 2 * KTO - 1));
      chk1("t5_req", req, !(TO_EN && (i == KTO - 1 || i == 2 * KTO - 1)));
      step();
    end
    give_key(128'h6666_0000_0000_0006, 64'h6666);
    smp();
    chk1("t5_late_inval", inval, 1'b1);
    pulse_done();
    fence = 1; step(); fence = 0;
    give_key(128'h7777_0000_0000_0007, 64'h7777);
    smp();
    chk1("t6_pre_inval", inval, 1'b1);
    rst = 1; step(); rst = 0;
    smp();
    chk1("t6_kvq", kvq, 1'b0);
    chkw("t6_key", kq, '0);
    chkw("t6_nonce", 128'(nq), '0);
    chk1("t6_inval", inval, 1'b0);
    chk1("t6_req", req, 1'b1);
    chk1("t6_busy", busy, 1'b1);
    chk1("v_rst_inval", inval1, 1'b1);
    chk1("v_rst_req", req1, 1'b0);
    step(); smp();
    chk1("v_kvq", kvq1, 1'b1);
    done1 = 1; step(); done1 = 0;
    smp();
    chk1("v_idle", busy1, 1'b0);
    fence1 = 1;
    give_key(128'h8888_0000_0000_0008, 64'h8888);
    fence1 = 0;
    smp();
    chk1("v_fence_inval", inval1, 1'b1);
    chk1("v_fence_req", req1, 1'b0);
    chk1("v_fence_busy", busy1, 1'b1);
    chkw("v_key_zero", kq1, '0);
    chkw("v_nonce_zero", 128'(nq1), '0);
    chk1("v_kvq_hold", kvq1, 1'b1);
    chk1("v_tmo", tmo1, 1'b0);
    repeat (2) step();
    chk1("queue_empty", exp_q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
